// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// Covers ALU op codes, MIPS mul/div op codes and the FSM state codes.
package alu_muldiv_seq_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_ADD = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b00010;

  typedef logic [1:0] md_op_t;

  localparam md_op_t MD_MULT  = 2'b00;
  localparam md_op_t MD_MULTU = 2'b01;
  localparam md_op_t MD_DIV   = 2'b10;
  localparam md_op_t MD_DIVU  = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  function automatic logic md_is_div(input md_op_t op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Core-side request/result bus of the mul/div sequencer, including the
// borrowed ALU operand/result path.
interface alu_muldiv_seq_if;
  import alu_muldiv_seq_pkg::*;

  logic            start;
  md_op_t          op;
  logic [XLEN-1:0] rs;
  logic [XLEN-1:0] rt;
  logic            hilo_we;
  logic            hilo_sel;
  logic [XLEN-1:0] hilo_wd;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] alu_c;
  logic            busy;
  logic            done;
  logic            div0;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs, rt, hilo_we, hilo_sel, hilo_wd, alu_c,
    input  alu_a, alu_b, alu_op, busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, hilo_we, hilo_sel, hilo_wd, alu_c,
    output alu_a, alu_b, alu_op, busy, done, div0, hi, lo
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational magnitude and negation helpers for the signed mul/div path:
// operand magnitudes before iterating and result negation afterwards.
module muldiv_sign_fix
  import alu_muldiv_seq_pkg::*;
(
  input  logic              is_signed,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  input  logic [2*XLEN-1:0] wide,
  output logic [2*XLEN-1:0] wide_neg,
  output logic [XLEN-1:0]   hi_neg,
  output logic [XLEN-1:0]   lo_neg
);

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  assign mag_a    = (is_signed && op_a[XLEN-1]) ? -op_a : op_a;
  assign mag_b    = (is_signed && op_b[XLEN-1]) ? -op_b : op_b;
  assign wide_neg = -wide;
  assign hi_neg   = -wide[2*XLEN-1:XLEN];
  assign lo_neg   = -wide[XLEN-1:0];

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that borrows the shared ALU one
// step per clock and owns the architectural HI/LO registers.
//
// state | meaning
// IDLE  | waiting; accepts start or MTHI/MTLO writes
// PRE   | take operand magnitudes, record signs, clear acc/counter
// ITER  | one shift-add or restoring-subtract step per cycle, XLEN cycles
// FIX   | apply sign fixup / divide-by-zero result, write hi/lo
// DONE  | done pulse, hi/lo valid
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  alu_muldiv_seq_if.slave bus
);

  logic [2:0]       state;
  md_op_t           op_q;
  logic [XLEN-1:0]  rs_q;
  logic [XLEN-1:0]  rt_q;
  logic [XLEN-1:0]  m_q;    // multiplicand or divisor magnitude
  logic [XLEN-1:0]  q_q;    // multiplier (shifting out) or quotient (shifting in)
  logic [XLEN-1:0]  acc_q;  // product high half or remainder
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;
  logic             sign_r;
  logic             div0_q;
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;

  logic             is_div;
  logic             is_signed;
  logic [XLEN-1:0]  rem_sh;
  logic             div_take;
  logic             carry;
  logic [XLEN-1:0]  alu_a_w;
  logic [XLEN-1:0]  alu_b_w;
  logic [4:0]       alu_op_w;

  logic [XLEN-1:0]   mag_rs;
  logic [XLEN-1:0]   mag_rt;
  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   acc_neg;
  logic [XLEN-1:0]   q_neg;

  assign is_div    = md_is_div(op_q);
  assign is_signed = md_is_signed(op_q);
  assign rem_sh    = {acc_q[XLEN-2:0], q_q[XLEN-1]};
  assign div_take  = acc_q[XLEN-1] | (rem_sh >= m_q);
  assign carry     = (alu_op_w == ALU_ADD) && (bus.alu_c < alu_a_w);

  muldiv_sign_fix u_sign_fix (
    .is_signed (is_signed),
    .op_a      (rs_q),
    .op_b      (rt_q),
    .mag_a     (mag_rs),
    .mag_b     (mag_rt),
    .wide      ({acc_q, q_q}),
    .wide_neg  (prod_neg),
    .hi_neg    (acc_neg),
    .lo_neg    (q_neg)
  );

  always_comb begin
    alu_a_w  = '0;
    alu_b_w  = '0;
    alu_op_w = ALU_NOP;
    if (state == ST_ITER) begin
      alu_b_w = m_q;
      if (is_div) begin
        alu_a_w  = rem_sh;
        alu_op_w = ALU_SUB;
      end else begin
        alu_a_w  = acc_q;
        alu_op_w = q_q[0] ? ALU_ADD : ALU_NOP;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      op_q   <= MD_MULT;
      rs_q   <= '0;
      rt_q   <= '0;
      m_q    <= '0;
      q_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div0_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            rs_q   <= bus.rs;
            rt_q   <= bus.rt;
            div0_q <= 1'b0;
            state  <= ST_PRE;
          end else if (bus.hilo_we) begin
            if (bus.hilo_sel) hi_q <= bus.hilo_wd;
            else              lo_q <= bus.hilo_wd;
          end
        end
        ST_PRE: begin
          m_q    <= is_div ? mag_rt : mag_rs;
          q_q    <= is_div ? mag_rs : mag_rt;
          acc_q  <= '0;
          cnt_q  <= '0;
          sign_q <= is_signed & (rs_q[XLEN-1] ^ rt_q[XLEN-1]);
          sign_r <= is_signed & rs_q[XLEN-1];
          div0_q <= is_div & (rt_q == '0);
          state  <= ST_ITER;
        end
        ST_ITER: begin
          if (is_div) begin
            acc_q <= div_take ? bus.alu_c : rem_sh;
            q_q   <= {q_q[XLEN-2:0], div_take};
          end else begin
            acc_q <= {carry, bus.alu_c[XLEN-1:1]};
            q_q   <= {bus.alu_c[0], q_q[XLEN-1:1]};
          end
          // Counter starts at 0 and wraps, so reaching 1 marks the XLEN-th step.
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (!is_div) begin
            {hi_q, lo_q} <= sign_q ? prod_neg : {acc_q, q_q};
          end else if (div0_q) begin
            lo_q <= '1;
            hi_q <= rs_q;
          end else begin
            lo_q <= sign_q ? q_neg : q_q;
            hi_q <= sign_r ? acc_neg : acc_q;
          end
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_a  = alu_a_w;
  assign bus.alu_b  = alu_b_w;
  assign bus.alu_op = alu_op_w;
  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = (state == ST_DONE);
  assign bus.div0   = div0_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq paired with a behavioural ADD/SUB/NOP ALU.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  alu_muldiv_seq_if bus ();

  alu_muldiv_seq dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always_comb begin
    case (bus.alu_op)
      ALU_ADD: bus.alu_c = bus.alu_a + bus.alu_b;
      ALU_SUB: bus.alu_c = bus.alu_a - bus.alu_b;
      default: bus.alu_c = bus.alu_a;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge while idle; returns once done is
  // seen (or the budget expires). hi_acc/div0_acc are sampled right after accept.
  task automatic do_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input int poke, output int lat,
                       output logic [31:0] hi_acc, output logic div0_acc,
                       output logic [31:0] hi_poke);
    bus.start = 1'b1;
    bus.op    = o;
    bus.rs    = a;
    bus.rt    = b;
    step();
    bus.start   = 1'b0;
    bus.hilo_we = 1'b0;
    hi_acc   = bus.hi;
    div0_acc = bus.div0;
    hi_poke  = bus.hi;
    lat = 0;
    while (!bus.done && lat < 100) begin
      step();
      lat++;
      if (lat == poke) begin
        bus.start    = 1'b1;
        bus.op       = MD_DIVU;
        bus.rs       = 32'h1;
        bus.rt       = 32'h1;
        bus.hilo_we  = 1'b1;
        bus.hilo_sel = 1'b1;
        bus.hilo_wd  = 32'hAAAA_AAAA;
      end else if (lat == poke + 1) begin
        bus.start   = 1'b0;
        bus.hilo_we = 1'b0;
        hi_poke     = bus.hi;
      end
    end
  endtask

  task automatic finish_op(input string tag);
    check_val({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
    step();
    check_val({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    check_val({tag, "_done_after"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] hi_acc;
    logic        div0_acc;
    logic [31:0] hi_poke;

    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    bus.start    = 1'b0;
    bus.op       = MD_MULT;
    bus.rs       = '0;
    bus.rt       = '0;
    bus.hilo_we  = 1'b0;
    bus.hilo_sel = 1'b0;
    bus.hilo_wd  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy",   32'(bus.busy),   32'd0);
    check_val("rst_done",   32'(bus.done),   32'd0);
    check_val("rst_div0",   32'(bus.div0),   32'd0);
    check_val("rst_hi",     bus.hi,          32'h0);
    check_val("rst_lo",     bus.lo,          32'h0);
    check_val("rst_alu_op", 32'(bus.alu_op), 32'(ALU_NOP));
    check_val("rst_alu_a",  bus.alu_a,       32'h0);
    rstn = 1'b1;
    step();

    // MTHI then MTLO
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_wd = 32'h1234;
    step();
    bus.hilo_we = 1'b0;
    check_val("mthi_hi", bus.hi, 32'h1234);
    check_val("mthi_lo", bus.lo, 32'h0);
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.hilo_wd = 32'h5678;
    step();
    bus.hilo_we = 1'b0;
    check_val("mtlo_lo", bus.lo, 32'h5678);
    check_val("mtlo_hi", bus.hi, 32'h1234);

    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -10, lat, hi_acc, div0_acc, hi_poke);
    check_val("multu_lat", 32'(lat), 32'd34);
    check_val("multu_hi",  bus.hi,   32'hFFFF_FFFE);
    check_val("multu_lo",  bus.lo,   32'h0000_0001);
    check_val("multu_div0", 32'(bus.div0), 32'd0);
    finish_op("multu");

    do_op(MD_MULT, 32'hFFFF_FFFD, 32'h7, -10, lat, hi_acc, div0_acc, hi_poke);
    check_val("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check_val("mult_lo", bus.lo, 32'hFFFF_FFEB);
    finish_op("mult");

    do_op(MD_DIV, 32'hFFFF_FFF9, 32'h2, -10, lat, hi_acc, div0_acc, hi_poke);
    check_val("div_lo", bus.lo, 32'hFFFF_FFFD);
    check_val("div_hi", bus.hi, 32'hFFFF_FFFF);
    finish_op("div");

    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -10, lat, hi_acc, div0_acc, hi_poke);
    check_val("ovf_lo", bus.lo, 32'h8000_0000);
    check_val("ovf_hi", bus.hi, 32'h0);
    finish_op("ovf");

    do_op(MD_DIVU, 32'd100, 32'd0, -10, lat, hi_acc, div0_acc, hi_poke);
    check_val("dz_lat",  32'(lat),      32'd34);
    check_val("dz_lo",   bus.lo,        32'hFFFF_FFFF);
    check_val("dz_hi",   bus.hi,        32'h0000_0064);
    check_val("dz_div0", 32'(bus.div0), 32'd1);
    finish_op("dz");
    check_val("dz_div0_sticky", 32'(bus.div0), 32'd1);

    // start together with a write: write dropped, div0 cleared on accept
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_wd = 32'hDEAD;
    do_op(MD_DIVU, 32'd100, 32'd7, -10, lat, hi_acc, div0_acc, hi_poke);
    check_val("coll_hi_kept", hi_acc, 32'h0000_0064);
    check_val("coll_div0_clr", 32'(div0_acc), 32'd0);
    check_val("divu_lo", bus.lo, 32'd14);
    check_val("divu_hi", bus.hi, 32'd2);
    finish_op("divu");

    // start and write while busy are ignored
    do_op(MD_MULT, 32'hFFFF_FFF0, 32'h10, 5, lat, hi_acc, div0_acc, hi_poke);
    check_val("busy_poke_hi",  hi_poke,  32'd2);
    check_val("busy_poke_lat", 32'(lat), 32'd34);
    check_val("busy_mult_hi",  bus.hi,   32'hFFFF_FFFF);
    check_val("busy_mult_lo",  bus.lo,   32'hFFFF_FF00);
    finish_op("busy");

    // reset after ten divide iterations
    bus.start = 1'b1; bus.op = MD_DIVU; bus.rs = 32'h1234_5678; bus.rt = 32'd3;
    step();
    bus.start = 1'b0;
    repeat (11) step();
    check_val("mid_alu_op", 32'(bus.alu_op), 32'(ALU_SUB));
    rstn = 1'b0;
    #1;
    check_val("mid_rst_busy",   32'(bus.busy),   32'd0);
    check_val("mid_rst_hi",     bus.hi,          32'h0);
    check_val("mid_rst_lo",     bus.lo,          32'h0);
    check_val("mid_rst_alu_op", 32'(bus.alu_op), 32'(ALU_NOP));
    check_val("mid_rst_alu_b",  bus.alu_b,       32'h0);
    step();
    rstn = 1'b1;
    step();

    do_op(MD_MULTU, 32'd6, 32'd7, -10, lat, hi_acc, div0_acc, hi_poke);
    check_val("rec_lo", bus.lo, 32'd42);
    check_val("rec_hi", bus.hi, 32'd0);
    finish_op("rec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that computes MIPS MULT/MULTU/DIV/DIVU by driving the shared 32-bit ALU iteratively.
- Uses ALU ADD for shift-add multiply and ALU SUB for restoring divide, one iteration per clock.
- Holds the architectural HI/LO registers and services MTHI/MTLO writes.
- Sits beside the ALU. The core's ALU-input mux selects this block's A/B/ALUOp while busy is high; the core stalls on busy.

Parameters:
- XLEN, 32, operand width. The iteration count equals XLEN.
- CNT_W, 5, iteration counter width, log2(XLEN).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs  in  32  operand 1: multiplicand or dividend.
- rt  in  32  operand 2: multiplier or divisor.
- hilo_we  in  1  MTHI/MTLO write strobe.
- hilo_sel  in  1  write target: 1 selects HI, 0 selects LO.
- hilo_wd  in  32  write data.
- alu_a  out  32  drives ALU A while busy.
- alu_b  out  32  drives ALU B while busy.
- alu_op  out  5  drives ALUOp; only `ALU_ADD, `ALU_SUB or `ALU_NOP.
- alu_c  in  32  ALU result C.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse; hi/lo are valid on that cycle.
- div0  out  1  sticky until next accepted start: last op was a divide by zero.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, rstn=0): state IDLE; hi, lo, counter, div0 = 0; busy=0, done=0; alu_op=`ALU_NOP; alu_a=alu_b=0. Reset at any point mid-operation aborts it with no partial hi/lo update.
- FSM: IDLE -> PRE -> ITER (XLEN cycles) -> FIX -> DONE -> IDLE.
- Latency: start accepted at edge 0; done is high during the cycle after edge 34, i.e. 35 cycles.
- IDLE:
  - start=1 latches op, rs, rt and clears div0.
  - Otherwise hilo_we writes hi or lo per hilo_sel.
  - start and hilo_we in the same cycle: start wins; the write is dropped.
- PRE: for signed ops, take magnitudes |rs| and |rt| locally (no ALU use). Record sign_q = rs[31]^rt[31] and sign_r = rs[31]. Clear the accumulator and the counter.
- ITER, multiply:
  - alu_a = acc_hi; alu_b = |mcand|.
  - alu_op = ADD if mplier LSB=1, else NOP (C=A).
  - carry = (alu_c <u alu_a) when ADD, else 0.
  - {acc_hi, mplier} <= {carry, alu_c, mplier} >> 1.
- ITER, divide:
  - Shift {rem, quot} left by 1; msb_out = rem[31] before the shift.
  - alu_a = shifted rem; alu_b = divisor; alu_op = SUB.
  - Accept when msb_out | (alu_a >=u alu_b): rem <= alu_c, quot LSB <= 1.
  - Otherwise rem is unchanged and quot LSB <= 0.
- Counter: decrements each ITER cycle; leaves ITER after the XLEN-th iteration (counter 0).
- FIX, signed ops only:
  - MULT with sign_q=1: negate the 64-bit product locally.
  - DIV with sign_q=1: negate the quotient.
  - DIV with sign_r=1: negate the remainder.
  - Then write hi/lo. Multiply: hi=product[63:32], lo=product[31:0]. Divide: lo=quotient, hi=remainder.
- Divide by zero (rt=0):
  - Iterations still run; div0=1.
  - Forced result lo=0xFFFFFFFF, hi=original rs. No sign fixup.
- Signed overflow 0x80000000/-1: lo=0x80000000, hi=0. Falls out naturally from the magnitude path.
- DONE: done=1 for one cycle, then IDLE. A new start is accepted in the following cycle.
- start or hilo_we while busy=1: ignored, no state effect.
- Outside PRE/ITER: alu_op=`ALU_NOP, alu_a=alu_b=0.

Decomposition:
- Shared package/include: reuse ctrl_encode_def.v for the `ALU_ADD/`ALU_SUB/`ALU_NOP codes.
- Add MD_MULT/MD_MULTU/MD_DIV/MD_DIVU op codes and the FSM state encodings to the same include file.
- One natural sub-module, muldiv_sign_fix: combinational abs and negate (32- and 64-bit), used by PRE and FIX.
- Bench pairs the block with the real alu instance.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 35 cycles after accept; carry path exercised.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=100 rt=0 -> lo=0xFFFFFFFF, hi=0x00000064, div0=1. Next accepted start clears div0.
- MTHI 0x1234 in IDLE -> hi=0x1234.
- start with hilo_we in the same cycle -> write dropped.
- start while busy -> ignored.
- rstn low at iteration 10 -> busy=0, hi=lo=0, alu_op=NOP immediately.
